// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard controller: in-flight writer scoreboard, forwarding selects, load-use stall
// and post-jump decode flush. Define HAZARD_FWD_EN to enable forwarding; otherwise any pending writer stalls.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES   = 3,
  parameter int REG_AW       = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              jmp,
  output logic              stall,
  output logic              issue_nop,
  output logic [3:0]        fwd_sel_a,
  output logic [3:0]        fwd_sel_b,
  output logic [31:0]       stall_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } sb_entry_t;

  sb_entry_t   sb_q [NUM_STAGES];
  sb_entry_t   sb_d [NUM_STAGES];
  logic [2:0]  flush_q, flush_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic       match_a, match_b, ld_a, ld_b, ready_a, ready_b;
  logic       load_wait_a, load_wait_b, hazard_a, hazard_b, issued;
  logic [3:0] idx_a, idx_b, fwd_a, fwd_b;

  // x0 is hardwired, so a pending write to it is never a dependency.
  function automatic logic hit(input sb_entry_t e, input logic [REG_AW-1:0] src, input logic used);
    return e.v && e.wr && (e.rd != '0) && (e.rd == src) && used;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    match_a = 1'b0;
    idx_a   = 4'd0;
    ld_a    = 1'b0;
    match_b = 1'b0;
    idx_b   = 4'd0;
    ld_b    = 1'b0;

    // Scan oldest to youngest so the youngest matching writer wins.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (hit(sb_q[i], id_rs1, id_rs1_used)) begin
        match_a = 1'b1;
        idx_a   = 4'(i);
        ld_a    = sb_q[i].ld;
      end
      if (hit(sb_q[i], id_rs2, id_rs2_used)) begin
        match_b = 1'b1;
        idx_b   = 4'(i);
        ld_b    = sb_q[i].ld;
      end
    end

    ready_a     = !ld_a || (idx_a >= 4'(LOAD_LAT));
    ready_b     = !ld_b || (idx_b >= 4'(LOAD_LAT));
    load_wait_a = match_a && !ready_a;
    load_wait_b = match_b && !ready_b;

`ifdef HAZARD_FWD_EN
    fwd_a    = (match_a && ready_a) ? idx_a + 4'd1 : 4'd0;
    fwd_b    = (match_b && ready_b) ? idx_b + 4'd1 : 4'd0;
    hazard_a = load_wait_a;
    hazard_b = load_wait_b;
`else
    // No bypass network: any pending writer blocks decode, a waiting load being one case of that.
    fwd_a    = 4'd0;
    fwd_b    = 4'd0;
    hazard_a = match_a || load_wait_a;
    hazard_b = match_b || load_wait_b;
`endif

    // Flush has priority over stall; everything is quiet while reset is held.
    issue_nop = reset && (jmp || (flush_q != 3'd0));
    stall     = reset && id_valid && (hazard_a || hazard_b) && !issue_nop;
    fwd_sel_a = reset ? fwd_a : 4'd0;
    fwd_sel_b = reset ? fwd_b : 4'd0;
    issued    = id_valid && !stall && !issue_nop;

    sb_d[0] = issued ? '{v: 1'b1, rd: id_rd, wr: id_regwrite, ld: id_memread} : '0;
    for (int i = 1; i < NUM_STAGES; i++) begin
      sb_d[i] = sb_q[i-1];
    end

    if (jmp) begin
      flush_d = 3'(FLUSH_CYCLES);
    end else if (flush_q != 3'd0) begin
      flush_d = flush_q - 3'd1;
    end else begin
      flush_d = 3'd0;
    end

    stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the scoreboard is a few flops whose valid bits must start clear, so unlike a RAM it is reset.
      for (int i = 0; i < NUM_STAGES; i++) begin
        sb_q[i] <= '0;
      end
      flush_q     <= 3'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sb_q        <= sb_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: history-queue reference model compared every cycle,
// plus directed scenarios with literal expectations. Honors HAZARD_FWD_EN like the design.
module tb_pipe_hazard_ctrl;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int LL = 1;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic          id_regwrite = 1'b0, id_memread = 1'b0, jmp = 1'b0;
  logic          stall, issue_nop;
  logic [3:0]    fwd_sel_a, fwd_sel_b;
  logic [31:0]   stall_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .REG_AW(AW), .LOAD_LAT(LL), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .jmp(jmp),
    .stall(stall), .issue_nop(issue_nop), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: hist[k] is the instruction issued k+1 cycles ago (age 0 = youngest).
  typedef struct { bit v; int rd; bit wr; bit ld; } mrec_t;
  mrec_t       hist[$];
  int          m_flush = 0;
  int unsigned m_scnt = 0;

  function automatic void model_clear();
    hist.delete();
    repeat (NS) hist.push_back('{0, 0, 0, 0});
    m_flush = 0;
    m_scnt  = 0;
  endfunction

  function automatic void find_src(input int src, input bit used, output bit found, output int age);
    found = 0;
    age   = 0;
    if (used && src != 0) begin
      foreach (hist[k]) begin
        if (!found && hist[k].v && hist[k].wr && hist[k].rd == src) begin
          found = 1;
          age   = k;
        end
      end
    end
  endfunction

  function automatic void model(output bit e_stall, output bit e_nop, output int e_fa, output int e_fb);
    bit fa, fb, wa, wb;
    int aa, ab;
    find_src(int'(id_rs1), id_rs1_used, fa, aa);
    find_src(int'(id_rs2), id_rs2_used, fb, ab);
    e_nop = reset && (jmp || m_flush > 0);
`ifdef HAZARD_FWD_EN
    wa   = fa && hist[aa].ld && aa < LL;
    wb   = fb && hist[ab].ld && ab < LL;
    e_fa = (reset && fa && !wa) ? aa + 1 : 0;
    e_fb = (reset && fb && !wb) ? ab + 1 : 0;
`else
    wa   = fa;
    wb   = fb;
    e_fa = 0;
    e_fb = 0;
`endif
    e_stall = reset && id_valid && (wa || wb) && !e_nop;
  endfunction

  always @(posedge clk or negedge reset) begin : model_upd
    bit s, n;
    int a, b;
    if (!reset) begin
      model_clear();
    end else begin
      model(s, n, a, b);
      if (id_valid && !s && !n) hist.push_front('{1, int'(id_rd), id_regwrite, id_memread});
      else                      hist.push_front('{0, 0, 0, 0});
      void'(hist.pop_back());
      m_flush = jmp ? FC : (m_flush > 0 ? m_flush - 1 : 0);
      if (s && m_scnt != 32'hFFFF_FFFF) m_scnt++;
    end
  end

  always @(negedge clk) begin : compare
    bit s, n;
    int a, b;
    if (cmp_en) begin
      model(s, n, a, b);
      check("model_stall", 32'(stall), 32'(s));
      check("model_issue_nop", 32'(issue_nop), 32'(n));
      check("model_fwd_sel_a", 32'(fwd_sel_a), 32'(a));
      check("model_fwd_sel_b", 32'(fwd_sel_b), 32'(b));
      check("model_stall_cnt", stall_cnt, m_scnt);
    end
  end

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit mr, input bit j);
    @(posedge clk);
    #1;
    id_valid    = v;
    id_rs1      = AW'(rs1);
    id_rs1_used = u1;
    id_rs2      = AW'(rs2);
    id_rs2_used = u2;
    id_rd       = AW'(rd);
    id_regwrite = rw;
    id_memread  = mr;
    jmp         = j;
    @(negedge clk);
  endtask

  task automatic hold();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct { bit v; int rs1; bit u1; int rs2; bit u2; int rd; bit rw; bit mr; bit j; } vec_t;
  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    vecs = '{
      '{1, 1, 1, 2, 1, 5, 1, 0, 0},
      '{1, 5, 1, 0, 0, 6, 1, 1, 0},
      '{1, 6, 1, 5, 1, 7, 1, 0, 0},
      '{1, 7, 1, 6, 1, 6, 1, 0, 0},
      '{1, 6, 1, 0, 0, 8, 1, 0, 1},
      '{1, 8, 1, 7, 1, 9, 1, 0, 0},
      '{1, 9, 1, 0, 0, 5, 1, 1, 0},
      '{1, 5, 1, 5, 0, 1, 1, 0, 0},
      '{1, 5, 1, 1, 1, 2, 1, 0, 0},
      '{0, 1, 1, 2, 1, 0, 0, 0, 0},
      '{1, 2, 1, 1, 1, 3, 0, 0, 0},
      '{1, 3, 1, 4, 1, 4, 1, 0, 0}
    };

    // Asynchronous reset with a jump request present: all outputs must stay quiet.
    #1;
    reset = 1'b0;
    jmp   = 1'b1;
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_issue_nop", 32'(issue_nop), 0);
    check("rst_fwd_a", 32'(fwd_sel_a), 0);
    check("rst_fwd_b", 32'(fwd_sel_b), 0);
    check("rst_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #2;
    jmp    = 1'b0;
    reset  = 1'b1;
    cmp_en = 1'b1;

    // ADD x5 then dependent ADD x6,x5,x1.
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
    check("add_x5_no_stall", 32'(stall), 0);
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    check("dep_fwd_a", 32'(fwd_sel_a), 1);
    check("dep_fwd_b", 32'(fwd_sel_b), 0);
    check("dep_no_stall", 32'(stall), 0);
`else
    for (int k = 0; k < 3; k++) begin
      check("nofwd_dep_stall", 32'(stall), 1);
      check("nofwd_dep_fwd_a", 32'(fwd_sel_a), 0);
      hold();
    end
    check("nofwd_dep_release", 32'(stall), 0);
`endif
    idle(3);

    // LW x7 then ADD x8,x7,x7.
    drive(1, 2, 1, 0, 0, 7, 1, 1, 0);
    drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    check("lu_stall", 32'(stall), 1);
    hold();
    check("lu_release", 32'(stall), 0);
    check("lu_fwd_a", 32'(fwd_sel_a), 2);
    check("lu_fwd_b", 32'(fwd_sel_b), 2);
    check("lu_stall_cnt", stall_cnt, 1);
`else
    for (int k = 0; k < 3; k++) begin
      check("nofwd_lu_stall", 32'(stall), 1);
      hold();
    end
    check("nofwd_lu_release", 32'(stall), 0);
    check("nofwd_lu_stall_cnt", stall_cnt, 6);
`endif
    idle(3);

    // ADDI x0 then ADD x3,x0,x0: x0 never matches.
    drive(1, 1, 1, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 3, 1, 0, 0);
    check("x0_fwd_a", 32'(fwd_sel_a), 0);
    check("x0_fwd_b", 32'(fwd_sel_b), 0);
    check("x0_no_stall", 32'(stall), 0);
    idle(3);

    // Jump while a load-use stall is pending: flush wins, load keeps advancing.
    drive(1, 2, 1, 0, 0, 9, 1, 1, 0);
    drive(1, 9, 1, 0, 0, 10, 1, 0, 1);
    check("jmp_stall", 32'(stall), 0);
    check("jmp_nop0", 32'(issue_nop), 1);
    drive(1, 9, 1, 0, 0, 10, 1, 0, 0);
    check("jmp_nop1", 32'(issue_nop), 1);
    check("jmp_stall1", 32'(stall), 0);
`ifdef HAZARD_FWD_EN
    check("jmp_load_at_1", 32'(fwd_sel_a), 2);
`endif
    hold();
    check("jmp_nop2", 32'(issue_nop), 1);
`ifdef HAZARD_FWD_EN
    check("jmp_load_at_2", 32'(fwd_sel_a), 3);
`endif
    drive(1, 10, 1, 0, 0, 11, 1, 0, 0);
    check("jmp_nop_end", 32'(issue_nop), 0);
    check("jmp_end_stall", 32'(stall), 0);
    check("jmp_killed_not_tracked", 32'(fwd_sel_a), 0);
    idle(3);

    // Asynchronous reset in the middle of a stall.
    drive(1, 2, 1, 0, 0, 12, 1, 1, 0);
    drive(1, 12, 1, 12, 1, 13, 1, 0, 0);
    check("pre_rst_stall", 32'(stall), 1);
    #3;
    reset = 1'b0;
    jmp   = 1'b1;
    #1;
    check("mid_rst_stall", 32'(stall), 0);
    check("mid_rst_issue_nop", 32'(issue_nop), 0);
    check("mid_rst_fwd_a", 32'(fwd_sel_a), 0);
    check("mid_rst_fwd_b", 32'(fwd_sel_b), 0);
    check("mid_rst_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #2;
    jmp      = 1'b0;
    id_valid = 1'b0;
    reset    = 1'b1;

    // Tracking resumes right after reset.
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
`ifdef HAZARD_FWD_EN
    check("post_rst_fwd_a", 32'(fwd_sel_a), 1);
    check("post_rst_fwd_b", 32'(fwd_sel_b), 1);
`else
    check("post_rst_stall", 32'(stall), 1);
`endif
    idle(3);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].j);
    end
    idle(4);

    cmp_en = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, meaning tracked in-flight stages after decode (index 0 = EX, NUM_STAGES-1 = WB); legal range 2..8.
REQ-002 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-003 SHALL have parameter LOAD_LAT, default 1, meaning the lowest stage index at which a load result is forwardable; legal range 1..NUM_STAGES-1.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 2, meaning decode-kill cycles after a taken jump; legal range 1..7.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 id_valid  input  1  decode holds a real instruction.
REQ-008 id_rs1, id_rs2  input  REG_AW each  decode source registers.
REQ-009 id_rs1_used, id_rs2_used  input  1 each  source is actually read.
REQ-010 id_rd  input  REG_AW  decode destination.
REQ-011 id_regwrite  input  1  decode instruction writes rd.
REQ-012 id_memread  input  1  decode instruction is a load.
REQ-013 jmp  input  1  taken jump/branch resolved in EX this cycle.
REQ-014 stall  output  1  hold PC and decode register.
REQ-015 issue_nop  output  1  replace decode output with a bubble.
REQ-016 fwd_sel_a, fwd_sel_b  output  4 each  operand source: 0 = register file, k = result of stage index k-1.
REQ-017 stall_cnt  output  32  saturating count of stall cycles.

Function
REQ-018 SHALL keep a scoreboard of NUM_STAGES entries {v, rd, wr, ld}; every edge entry i takes entry i-1 and entry 0 takes {1, id_rd, id_regwrite, id_memread} when issued, else all-zero.
REQ-019 SHALL define issued = id_valid AND NOT stall AND NOT issue_nop.
REQ-020 SHALL define a match on entry i for a source: v AND wr AND rd != 0 AND rd == source AND source-used.
REQ-021 SHALL evaluate only the youngest (lowest-index) matching entry per source; register x0 never matches.
REQ-022 SHALL treat entry i as ready when NOT ld OR i >= LOAD_LAT.
REQ-023 SHALL drive fwd_sel = i+1 for a ready youngest match, 0 on no match; combinational from scoreboard and id inputs, zero latency.
REQ-024 SHALL assert stall combinationally when either source's youngest match is not ready (load-use), provided id_valid.
REQ-025 SHALL load an internal flush counter with FLUSH_CYCLES on jmp, reloading if jmp recurs while non-zero; decrement to 0 otherwise.
REQ-026 SHALL assert issue_nop when jmp is high or flush counter is non-zero.
REQ-027 SHALL force stall to 0 whenever issue_nop is 1 (flush beats stall); scoreboard entry 0 receives a bubble.
REQ-028 SHALL NOT kill the jumping instruction already in entry 0; it advances normally.
REQ-029 SHALL increment stall_cnt each cycle stall is 1, saturating at 0xFFFFFFFF.
REQ-030 SHALL leave fwd_sel valid (not zeroed) during stall so the held decode instruction sees correct values.

Reset
REQ-031 SHALL on reset low clear all scoreboard entries, flush counter and stall_cnt immediately, regardless of clk.
REQ-032 SHALL drive stall=0, issue_nop=0, fwd_sel_a=fwd_sel_b=0 while reset is low, including mid-flush or mid-stall.
REQ-033 SHALL resume normal tracking on the first rising edge after reset deasserts.

Configuration
REQ-034 With HAZARD_FWD_EN defined, forwarding per REQ-022..REQ-024 SHALL apply.
REQ-035 Without HAZARD_FWD_EN, fwd_sel_a/fwd_sel_b SHALL be constant 0 and stall SHALL assert on any match in any entry (ready or not), still subject to REQ-027.

Verification
REQ-036 HAZARD_FWD_EN, defaults: issue ADD x5 then decode ADD x6,x5,x1 next cycle -> fwd_sel_a=1, fwd_sel_b=0, stall=0.
REQ-037 HAZARD_FWD_EN: LW x7 then decode ADD x8,x7,x7 -> stall=1 for exactly 1 cycle, then fwd_sel_a=fwd_sel_b=2; stall_cnt increments to 1.
REQ-038 Decode ADD x3,x0,x0 after ADDI x0 with regwrite=1 -> fwd_sel=0, no stall.
REQ-039 jmp pulse for one cycle while a load-use stall is pending -> stall=0, issue_nop=1 for 3 cycles (jmp cycle + FLUSH_CYCLES), entry 0 bubbles.
REQ-040 HAZARD_FWD_EN undefined: ADD x5 then dependent ADD x6,x5,x0 -> stall=1 for 3 cycles, fwd_sel stays 0.
REQ-041 Reset low asserted asynchronously mid-stall -> stall, issue_nop, fwd_sel drop to 0 before next edge; stall_cnt=0.
